// File: rtl/eic_pkg.sv
// Shared definitions for the external interrupt controller: register
// offsets, FSM state encoding and CTRL bit positions.
package eic_pkg;

  localparam int unsigned EIC_REG_W = 2;

  // Register offsets relative to BASE_ADDR
  localparam logic [EIC_REG_W-1:0] EIC_REG_CTRL  = 2'd0;
  localparam logic [EIC_REG_W-1:0] EIC_REG_MASK  = 2'd1;
  localparam logic [EIC_REG_W-1:0] EIC_REG_PEND  = 2'd2;
  localparam logic [EIC_REG_W-1:0] EIC_REG_CLAIM = 2'd3;

  // CTRL register bit positions
  localparam int unsigned EIC_CTRL_GE = 0;

  typedef enum logic [1:0] {
    EIC_ST_IDLE    = 2'd0,
    EIC_ST_REQ     = 2'd1,
    EIC_ST_SERVICE = 2'd2
  } eic_state_e;

endpackage

// File: rtl/eic_priority_select.sv
// Find-first-set over NUM_IRQ request bits, searching upward from start
// and wrapping around.
// Ports:
//   req      - candidate request vector
//   start    - index where the search begins (0 for fixed priority)
//   id_c     - first set index found (0 when none)
//   found_c  - at least one request bit set
module eic_priority_select #(
  parameter int unsigned NUM_IRQ = 8,
  parameter int unsigned ID_W    = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  input  logic [ID_W-1:0]    start,
  output logic [ID_W-1:0]    id_c,
  output logic               found_c
);

  int unsigned idx;

  // Wrapping scan; the first hit from start wins
  always_comb begin
    id_c    = '0;
    found_c = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      idx = 32'(start) + i;
      if (idx >= NUM_IRQ) idx = idx - NUM_IRQ;
      if (!found_c && req[ID_W'(idx)]) begin
        found_c = 1'b1;
        id_c    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/external_interrupt_controller.sv
// External interrupt controller: synchronizes NUM_IRQ async lines, detects
// rising edges into PEND, and delivers one interrupt at a time to the core
// through a request/acknowledge/EOI sequence. Memory-mapped on the IO bus.
// Optional: define EIC_ROUND_ROBIN_EN for rotating priority (search starts
// after the last acknowledged ID); otherwise the lowest index wins.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   irq_in                - async interrupt lines (rising edge significant)
//   int_req, int_id       - request and ID to the core
//   int_ack               - one-cycle acknowledge from the core
//   in_service            - high from acknowledge until EOI
//   io_en_r, io_en_w      - IO read / write strobes
//   io_address            - IO word address
//   io_data_w, io_data_r  - IO write data / registered read data
module external_interrupt_controller
  import eic_pkg::*;
#(
  parameter int unsigned NUM_IRQ   = 8,
  parameter int unsigned ID_W      = $clog2(NUM_IRQ),
  parameter logic [29:0] BASE_ADDR = 30'h3FFF_FFF0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               int_req,
  output logic [ID_W-1:0]    int_id,
  input  logic               int_ack,
  output logic               in_service,
  input  logic               io_en_r,
  input  logic               io_en_w,
  input  logic [29:0]        io_address,
  input  logic [31:0]        io_data_w,
  output logic [31:0]        io_data_r
);

  logic [NUM_IRQ-1:0] sync1, sync2, hist, rise;
  logic [NUM_IRQ-1:0] mask, pend, eligible, w1c_clr, ack_clr;
  logic               ge;
  logic [29:0]        offset;
  logic               addr_hit, wr_en, rd_en, eoi;
  logic [EIC_REG_W-1:0] reg_sel;
  logic [31:0]        rd_data;
  logic [ID_W-1:0]    start_idx, sel_id;
  logic               sel_found;
  eic_state_e         state, state_n;
  logic               int_req_n, in_service_n;
  logic [ID_W-1:0]    int_id_n;
  logic               unused_data_w;

  assign unused_data_w = ^io_data_w;

  // Address decode: only offsets 0..3 from BASE_ADDR respond
  assign offset   = io_address - BASE_ADDR;
  assign addr_hit = (offset < 30'd4);
  assign reg_sel  = offset[EIC_REG_W-1:0];
  assign wr_en    = io_en_w & addr_hit;
  assign rd_en    = io_en_r & addr_hit;
  assign eoi      = wr_en && (reg_sel == EIC_REG_CLAIM);
  assign w1c_clr  = (wr_en && (reg_sel == EIC_REG_PEND)) ? io_data_w[NUM_IRQ-1:0] : '0;

  // Two-flop synchronizer plus history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign rise = sync2 & ~hist;

  // CTRL and MASK registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ge   <= 1'b0;
      mask <= '0;
    end else if (wr_en) begin
      if (reg_sel == EIC_REG_CTRL) ge   <= io_data_w[EIC_CTRL_GE];
      if (reg_sel == EIC_REG_MASK) mask <= io_data_w[NUM_IRQ-1:0];
    end
  end

  // Pending bits: a new edge beats any same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= (pend & ~(w1c_clr | ack_clr)) | rise;
  end

  assign eligible = ge ? (pend & mask) : '0;

`ifdef EIC_ROUND_ROBIN_EN
  logic [ID_W-1:0] last_id;

  // Last acknowledged ID; reset value makes the first search start at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              last_id <= ID_W'(NUM_IRQ - 1);
    else if (state == EIC_ST_REQ && int_ack) last_id <= int_id;
  end

  assign start_idx = (last_id == ID_W'(NUM_IRQ - 1)) ? '0 : last_id + ID_W'(1);
`else
  assign start_idx = '0;
`endif

  eic_priority_select #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_select (
    .req     (eligible),
    .start   (start_idx),
    .id_c    (sel_id),
    .found_c (sel_found)
  );

  // FSM and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EIC_ST_IDLE;
      int_req    <= 1'b0;
      int_id     <= '0;
      in_service <= 1'b0;
    end else begin
      state      <= state_n;
      int_req    <= int_req_n;
      int_id     <= int_id_n;
      in_service <= in_service_n;
    end
  end

  // Next state; int_req rises one cycle after the ID is latched
  always_comb begin
    state_n      = state;
    int_req_n    = int_req;
    int_id_n     = int_id;
    in_service_n = in_service;
    ack_clr      = '0;
    case (state)
      EIC_ST_IDLE: begin
        int_req_n = 1'b0;
        if (sel_found) begin
          int_id_n = sel_id;
          state_n  = EIC_ST_REQ;
        end
      end
      EIC_ST_REQ: begin
        if (int_ack) begin
          ack_clr[int_id] = 1'b1;
          in_service_n    = 1'b1;
          int_req_n       = 1'b0;
          state_n         = EIC_ST_SERVICE;
        end else if (!ge || !mask[int_id]) begin
          int_req_n = 1'b0;
          state_n   = EIC_ST_IDLE;
        end else begin
          int_req_n = 1'b1;
        end
      end
      EIC_ST_SERVICE: begin
        int_req_n = 1'b0;
        if (eoi) begin
          in_service_n = 1'b0;
          state_n      = EIC_ST_IDLE;
        end
      end
      default: begin
        int_req_n = 1'b0;
        state_n   = EIC_ST_IDLE;
      end
    endcase
  end

  // Register read mux
  always_comb begin
    rd_data = '0;
    case (reg_sel)
      EIC_REG_CTRL:  rd_data = {31'd0, ge};
      EIC_REG_MASK:  rd_data = 32'(mask);
      EIC_REG_PEND:  rd_data = 32'(pend);
      EIC_REG_CLAIM: rd_data = {in_service, {(31 - ID_W){1'b0}}, int_id};
      default:       rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     io_data_r <= '0;
    else if (rd_en) io_data_r <= rd_data;
  end

endmodule

// File: tb/tb_external_interrupt_controller.sv
module tb_external_interrupt_controller;

  localparam int unsigned N    = 8;
  localparam int unsigned ID_W = 3;
  localparam logic [29:0] BASE = 30'h3FFF_FFF0;
  localparam int PH_IDLE = 0;
  localparam int PH_REQ  = 1;
  localparam int PH_SVC  = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    irq_in = '0;
  logic            int_req;
  logic [ID_W-1:0] int_id;
  logic            int_ack = 1'b0;
  logic            in_service;
  logic            io_en_r = 1'b0;
  logic            io_en_w = 1'b0;
  logic [29:0]     io_address = '0;
  logic [31:0]     io_data_w = '0;
  logic [31:0]     io_data_r;

  external_interrupt_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_in     (irq_in),
    .int_req    (int_req),
    .int_id     (int_id),
    .int_ack    (int_ack),
    .in_service (in_service),
    .io_en_r    (io_en_r),
    .io_en_w    (io_en_w),
    .io_address (io_address),
    .io_data_w  (io_data_w),
    .io_data_r  (io_data_r)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic        chk_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [N-1:0]    seen [3];        // line samples taken 1, 2 and 3 edges ago
  logic            m_ge, m_req, m_ins;
  logic [N-1:0]    m_mask, m_pend;
  logic [ID_W-1:0] m_id;
  logic [31:0]     m_rd;
  int              m_phase;
  int unsigned     m_last;
  logic [29:0]     t_off;
  logic            t_wr, t_rd, t_eoi;
  logic [N-1:0]    t_rise, t_elig, t_clr;
  int unsigned     t_start;

  function automatic logic [ID_W-1:0] pick(input logic [N-1:0] e, input int unsigned start);
    for (int k = 0; k < N; k++) begin
      int unsigned j;
      j = (start + k) % N;
      if (e[j]) return ID_W'(j);
    end
    return '0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) seen[k] = '0;
      m_ge = 0; m_req = 0; m_ins = 0; m_mask = '0; m_pend = '0;
      m_id = '0; m_rd = '0; m_phase = PH_IDLE; m_last = N - 1;
    end else begin
      t_off = io_address - BASE;
      t_wr  = io_en_w && (t_off < 4);
      t_rd  = io_en_r && (t_off < 4);
      t_eoi = t_wr && (t_off == 3);
      t_rise = seen[1] & ~seen[2];
      seen[2] = seen[1];
      seen[1] = seen[0];
      seen[0] = irq_in;
      if (t_rd) begin
        case (t_off)
          0: m_rd = {31'd0, m_ge};
          1: m_rd = {24'd0, m_mask};
          2: m_rd = {24'd0, m_pend};
          default: m_rd = {m_ins, 28'd0, m_id};
        endcase
      end
      t_elig = m_ge ? (m_pend & m_mask) : '0;
      t_clr  = (t_wr && t_off == 2) ? io_data_w[N-1:0] : '0;
`ifdef EIC_ROUND_ROBIN_EN
      t_start = (m_last + 1) % N;
`else
      t_start = 0;
`endif
      case (m_phase)
        PH_IDLE: begin
          m_req = 0;
          if (t_elig != 0) begin
            m_id = pick(t_elig, t_start);
            m_phase = PH_REQ;
          end
        end
        PH_REQ: begin
          if (int_ack) begin
            t_clr[m_id] = 1'b1;
            m_ins = 1; m_req = 0; m_last = m_id; m_phase = PH_SVC;
          end else if (!m_ge || !m_mask[m_id]) begin
            m_req = 0; m_phase = PH_IDLE;
          end else begin
            m_req = 1;
          end
        end
        default: begin
          m_req = 0;
          if (t_eoi) begin
            m_ins = 0; m_phase = PH_IDLE;
          end
        end
      endcase
      m_pend = (m_pend & ~t_clr) | t_rise;
      if (t_wr && t_off == 0) m_ge = io_data_w[0];
      if (t_wr && t_off == 1) m_mask = io_data_w[N-1:0];
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      check("int_req", 32'(int_req), 32'(m_req));
      check("int_id", 32'(int_id), 32'(m_id));
      check("in_service", 32'(in_service), 32'(m_ins));
      check("io_data_r", io_data_r, m_rd);
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic io_write(input int unsigned off, input logic [31:0] d);
    io_en_w = 1'b1; io_address = BASE + 30'(off); io_data_w = d;
    @(negedge clk);
    io_en_w = 1'b0;
  endtask

  task automatic io_read(input int unsigned off, output logic [31:0] d);
    io_en_r = 1'b1; io_address = BASE + 30'(off);
    @(negedge clk);
    io_en_r = 1'b0;
    d = io_data_r;
  endtask

  task automatic ack_pulse();
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
  endtask

  task automatic wait_req(input int unsigned max_cyc);
    int unsigned cnt = 0;
    while (!int_req && cnt < max_cyc) begin
      @(negedge clk);
      cnt++;
    end
    check("req_wait", 32'(int_req), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  logic [31:0] d;
  logic [31:0] exp_first, exp_second;

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst_int_req", 32'(int_req), 32'd0);
    check("rst_in_service", 32'(in_service), 32'd0);
    check("rst_int_id", 32'(int_id), 32'd0);
    check("rst_io_data_r", io_data_r, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1'b1;

    // Configuration and readback
    io_write(1, 32'hFF);
    io_write(0, 32'h1);
    io_read(0, d); check("rd_ctrl", d, 32'h1);
    io_read(1, d); check("rd_mask", d, 32'hFF);
    io_read(4, d); check("rd_nodecode", d, 32'hFF);
    io_read(2, d); check("rd_pend", d, 32'h0);
    io_read(3, d); check("rd_claim", d, 32'h0);

    // Single delivery on line 3
    irq_in[3] = 1'b1;
    repeat (3) @(negedge clk);
    io_read(2, d); check("pend_line3", d, 32'h08);
    check("req_not_yet", 32'(int_req), 32'd0);
    @(negedge clk);
    check("req_line3", 32'(int_req), 32'd1);
    check("id_line3", 32'(int_id), 32'd3);
    ack_pulse();
    check("req_after_ack", 32'(int_req), 32'd0);
    check("ins_after_ack", 32'(in_service), 32'd1);
    io_read(2, d); check("pend_after_ack", d, 32'h0);
    io_read(3, d); check("claim_in_service", d, 32'h8000_0003);
    io_write(3, 32'h0);
    check("ins_after_eoi", 32'(in_service), 32'd0);
    irq_in[3] = 1'b0;

    // Priority between lines 5 and 2
`ifdef EIC_ROUND_ROBIN_EN
    exp_first = 32'd5; exp_second = 32'd2;
`else
    exp_first = 32'd2; exp_second = 32'd5;
`endif
    irq_in[5] = 1'b1; irq_in[2] = 1'b1;
    wait_req(20);
    check("prio_first", 32'(int_id), exp_first);
    ack_pulse();
    io_write(3, 32'h0);
    wait_req(20);
    check("prio_second", 32'(int_id), exp_second);
    ack_pulse();
    io_write(3, 32'h0);
    irq_in[5] = 1'b0; irq_in[2] = 1'b0;

    // Withdrawal by masking while requesting
    irq_in[4] = 1'b1;
    wait_req(20);
    check("id_line4", 32'(int_id), 32'd4);
    io_write(1, 32'hEF);
    @(negedge clk);
    check("withdrawn", 32'(int_req), 32'd0);
    io_read(2, d); check("pend_kept", d, 32'h10);
    io_write(1, 32'hFF);
    wait_req(20);
    check("reassert_id", 32'(int_id), 32'd4);
    ack_pulse();
    io_write(3, 32'h0);
    irq_in[4] = 1'b0;

    // Set/clear collision and held level
    io_write(1, 32'h0);
    irq_in[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    io_write(2, 32'h1);
    io_read(2, d); check("collision_set_wins", d, 32'h1);
    io_write(2, 32'h1);
    repeat (10) @(negedge clk);
    io_read(2, d); check("level_single_set", d, 32'h0);
    irq_in[0] = 1'b0;

    // Asynchronous reset while in service
    io_write(1, 32'hFF);
    irq_in[6] = 1'b1;
    wait_req(20);
    ack_pulse();
    io_read(3, d); check("claim_line6", d, 32'h8000_0006);
    #1 rst_n = 1'b0; irq_in = '0;
    #1;
    check("async_int_req", 32'(int_req), 32'd0);
    check("async_in_service", 32'(in_service), 32'd0);
    check("async_io_data_r", io_data_r, 32'd0);
    check("async_int_id", 32'(int_id), 32'd0);
    check("async_mask", 32'(dut.mask), 32'd0);
    check("async_pend", 32'(dut.pend), 32'd0);
    check("async_ge", 32'(dut.ge), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    io_read(0, d); check("post_rst_ctrl", d, 32'h0);
    io_read(1, d); check("post_rst_mask", d, 32'h0);

    // Randomized traffic checked by the model
    io_write(1, 32'hFF);
    io_write(0, 32'h1);
    for (int c = 0; c < 3000; c++) begin
      int unsigned r;
      io_en_r = 1'b0; io_en_w = 1'b0; int_ack = 1'b0;
      for (int b = 0; b < N; b++)
        if ($urandom_range(15) == 0) irq_in[b] = ~irq_in[b];
      if (int_req && $urandom_range(2) == 0) int_ack = 1'b1;
      else if (m_phase != PH_REQ && $urandom_range(49) == 0) int_ack = 1'b1;
      r = $urandom_range(15);
      io_data_w = $urandom;
      case (r)
        0, 1, 2: begin
          io_en_r = 1'b1;
          io_address = BASE - 30'd2 + 30'($urandom_range(7));
        end
        3: begin
          io_en_w = 1'b1; io_address = BASE;
          io_data_w = {31'd0, ($urandom_range(7) != 0)};
        end
        4: begin io_en_w = 1'b1; io_address = BASE + 30'd1; end
        5: begin io_en_w = 1'b1; io_address = BASE + 30'd2; end
        6, 7: begin io_en_w = 1'b1; io_address = BASE + 30'd3; end
        8: begin io_en_w = 1'b1; io_address = BASE + 30'd4; end
        default: ;
      endcase
      @(negedge clk);
    end
    io_en_r = 1'b0; io_en_w = 1'b0; int_ack = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
